buffer_sequencer: RTL and testbench

BUFFER_SEQUENCER -- requirements
Module: buffer_sequencer

---
 rtl/buffer_seq_pkg.sv | 17 +
 rtl/rr_arb2.sv | 36 +++
 rtl/buffer_sequencer.sv | 116 +++++++++++
 tb/tb_buffer_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_seq_pkg.sv
// Shared definitions for the buffer sequencer: default sizes, state encoding and
// the request/grant bit positions used by the round-robin arbiter.
package buffer_seq_pkg;

  localparam int unsigned CapacityDefault = 1024;
  localparam int unsigned CntWDefault     = 11;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRecord   = 2'd1;
  localparam logic [1:0] StTransmit = 2'd2;
  localparam logic [1:0] StDone     = 2'd3;

  // Bit positions within the two-bit request and grant vectors.
  localparam int unsigned GntRec = 0;
  localparam int unsigned GntTx  = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester not granted last wins;
// the last-grant flag resets to "record", so transmit wins the first tie.
module rr_arb2
  import buffer_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_tx_q;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = 2'b00;
      if (last_tx_q) begin
        grant[GntRec] = 1'b1;
      end else begin
        grant[GntTx] = 1'b1;
      end
    end
  end

  // The flag only moves when the grant is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_tx_q <= 1'b0;
    end else if (en && (grant != 2'b00)) begin
      last_tx_q <= grant[GntTx];
    end
  end

endmodule

// File: rtl/buffer_sequencer.sv
// Sequences record and transmit phases of an external bit buffer between two
// requesters, driving the buffer's record and output-advance enables.
module buffer_sequencer
  import buffer_seq_pkg::*;
#(
  parameter int unsigned CAPACITY = CapacityDefault,
  parameter int unsigned CNT_W    = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rec_req,
  input  logic             tx_req,
  input  logic             abort,
  input  logic [CNT_W-1:0] bits_used,
  input  logic             tx_ready,
  output logic             record_bits,
  output logic             output_bits,
  output logic             tx_valid,
  output logic             busy,
  output logic             full,
  output logic             empty,
  output logic             frame_done,
  output logic [CNT_W-1:0] tx_count
);

  localparam logic [CNT_W-1:0] CapBits = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] OneBit  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
  logic [1:0]       req, grant;
  logic             grant_en;

  // Overfilled buffers count as full.
  assign full  = (bits_used >= CapBits);
  assign empty = (bits_used == '0);

  assign req[GntTx]  = tx_req && !empty;
  assign req[GntRec] = rec_req && !full;
  assign grant_en    = (state_q == StIdle) && !rst;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (grant_en),
    .grant (grant)
  );

  // Outputs are forced low while reset is held so nothing leaks out mid-reset.
  always_comb begin
    record_bits = 1'b0;
    output_bits = 1'b0;
    tx_valid    = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    if (!rst) begin
      busy = (state_q != StIdle);
      case (state_q)
        StRecord: record_bits = rec_req && !full && !abort;
        StTransmit: begin
          tx_valid    = !empty;
          output_bits = tx_ready && !empty && !abort;
        end
        StDone:  frame_done = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_count_d = tx_count_q;
    case (state_q)
      StIdle: begin
        if (grant[GntTx]) begin
          state_d    = StTransmit;
          tx_count_d = '0;
        end else if (grant[GntRec]) begin
          state_d = StRecord;
        end
      end
      StRecord: begin
        if (!rec_req || full || abort) begin
          state_d = StIdle;
        end
      end
      StTransmit: begin
        if (output_bits) begin
          tx_count_d = tx_count_q + OneBit;
        end
        // Abort leaves the count as-is and skips the completion pulse.
        if (abort) begin
          state_d = StIdle;
        end else if ((output_bits && (bits_used == OneBit)) || empty) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign tx_count = tx_count_q;

endmodule

// File: tb/tb_buffer_sequencer.sv
// Bench for buffer_sequencer: directed scenarios then random traffic, every cycle
// checked against a phase-level reference model with a simple fill-level buffer.
module tb_buffer_sequencer;

  localparam int Cap  = 1024;
  localparam int CntW = 11;

  logic            clk = 1'b0;
  logic            rst, rec_req, tx_req, abort, tx_ready;
  logic [CntW-1:0] bits_used;
  logic            record_bits, output_bits, tx_valid, busy, full, empty, frame_done;
  logic [CntW-1:0] tx_count;

  always #5 clk = ~clk;

  buffer_sequencer #(
    .CAPACITY (Cap),
    .CNT_W    (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rec_req     (rec_req),
    .tx_req      (tx_req),
    .abort       (abort),
    .bits_used   (bits_used),
    .tx_ready    (tx_ready),
    .record_bits (record_bits),
    .output_bits (output_bits),
    .tx_valid    (tx_valid),
    .busy        (busy),
    .full        (full),
    .empty       (empty),
    .frame_done  (frame_done),
    .tx_count    (tx_count)
  );

  typedef enum int {PhIdle, PhRecord, PhSend, PhDone} phase_e;

  phase_e ph;
  bit     tie_to_tx;  // next tie goes to the transmitter
  int     sent;       // bits handed downstream in the current/last frame
  bit     e_rec, e_out;
  int     n_cmp, n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and compare every output against the model.
  task automatic drive(input bit r, input bit rq, input bit tq, input bit ab, input bit rdy,
                       input int bu);
    bit f, e;
    @(negedge clk);
    rst       = r;
    rec_req   = rq;
    tx_req    = tq;
    abort     = ab;
    tx_ready  = rdy;
    bits_used = CntW'(bu);
    #1;
    f     = (bu >= Cap);
    e     = (bu == 0);
    e_rec = !r && (ph == PhRecord) && rq && !f && !ab;
    e_out = !r && (ph == PhSend) && rdy && !e && !ab;
    check_eq("full", 32'(full), 32'(f));
    check_eq("empty", 32'(empty), 32'(e));
    check_eq("record_bits", 32'(record_bits), 32'(e_rec));
    check_eq("output_bits", 32'(output_bits), 32'(e_out));
    check_eq("tx_valid", 32'(tx_valid), 32'(!r && (ph == PhSend) && !e));
    check_eq("busy", 32'(busy), 32'(!r && (ph != PhIdle)));
    check_eq("frame_done", 32'(frame_done), 32'(!r && (ph == PhDone)));
    check_eq("tx_count", 32'(tx_count), 32'(sent % (1 << CntW)));
  endtask

  // Advance the model across the clock edge using the inputs currently applied.
  task automatic tick();
    bit f, e, want_tx, want_rec;
    int bu;
    @(posedge clk);
    bu = int'(bits_used);
    f  = (bu >= Cap);
    e  = (bu == 0);
    if (rst) begin
      ph        = PhIdle;
      tie_to_tx = 1'b1;
      sent      = 0;
    end else begin
      case (ph)
        PhIdle: begin
          want_tx  = tx_req && !e;
          want_rec = rec_req && !f;
          if (want_tx && (!want_rec || tie_to_tx)) begin
            ph        = PhSend;
            sent      = 0;
            tie_to_tx = 1'b0;
          end else if (want_rec) begin
            ph        = PhRecord;
            tie_to_tx = 1'b1;
          end
        end
        PhRecord: if (!rec_req || f || abort) ph = PhIdle;
        PhSend: begin
          if (e_out) sent++;
          if (abort) ph = PhIdle;
          else if ((e_out && bu == 1) || e) ph = PhDone;
        end
        default: ph = PhIdle;
      endcase
    end
  endtask

  initial begin
    bit rdy_pat[4];
    int bu_pat[4];
    int bu;
    bit r, rq, tq, ab, rdy;
    rdy_pat   = '{1'b1, 1'b0, 1'b1, 1'b1};
    bu_pat    = '{3, 2, 2, 1};
    n_cmp     = 0;
    n_err     = 0;
    ph        = PhIdle;
    tie_to_tx = 1'b1;
    sent      = 0;
    rst = 1'b1; rec_req = 1'b0; tx_req = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    bits_used = '0;

    // Record from empty, release at 16 bits.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0); tick();
    for (int b = 0; b < 16; b++) begin
      drive(0, 1, 0, 0, 0, b);
      check_eq("rec_enable_on", 32'(record_bits), 32'd1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 16);
    check_eq("rec_release_enable", 32'(record_bits), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 16);
    check_eq("rec_release_idle", 32'(busy), 32'd0);
    tick();

    // Simultaneous requests after reset: transmit first, then record.
    drive(1, 0, 0, 0, 0, 8); tick();
    drive(0, 1, 1, 0, 0, 8); tick();
    drive(0, 1, 1, 0, 0, 8);
    check_eq("tie_first_tx", 32'(tx_valid), 32'd1);
    tick();
    for (int b = 8; b >= 1; b--) begin
      drive(0, 1, 1, 0, 1, b); tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check_eq("drain_frame_done", 32'(frame_done), 32'd1);
    tick();
    drive(0, 1, 1, 0, 0, 8); tick();
    drive(0, 1, 1, 0, 0, 8);
    check_eq("tie_second_rec", 32'(record_bits), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 8); tick();

    // Three-bit frame with tx_ready stalling; tx_req dropped after grant.
    drive(0, 0, 1, 0, 0, 3); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, rdy_pat[i], bu_pat[i]);
      check_eq("stall_output_bits", 32'(output_bits), 32'(rdy_pat[i]));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    check_eq("stall_tx_count", 32'(tx_count), 32'd3);
    check_eq("stall_frame_done", 32'(frame_done), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check_eq("frame_done_one_cycle", 32'(frame_done), 32'd0);
    tick();

    // Full buffer blocks a lone record request.
    drive(0, 1, 0, 0, 0, 1024); tick();
    drive(0, 1, 0, 0, 0, 1024);
    check_eq("full_stays_idle", 32'(busy), 32'd0);
    check_eq("full_flag", 32'(full), 32'd1);
    check_eq("full_no_record", 32'(record_bits), 32'd0);
    tick();

    // Abort after five bits.
    drive(0, 0, 1, 0, 0, 20); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 20 - i); tick();
    end
    drive(0, 0, 0, 1, 1, 15);
    check_eq("abort_blocks_output", 32'(output_bits), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 15);
    check_eq("abort_idle", 32'(busy), 32'd0);
    check_eq("abort_tx_count", 32'(tx_count), 32'd5);
    check_eq("abort_no_done", 32'(frame_done), 32'd0);
    tick();

    // Reset while recording.
    drive(0, 1, 0, 0, 0, 15); tick();
    drive(0, 1, 0, 0, 0, 15);
    check_eq("pre_reset_record", 32'(record_bits), 32'd1);
    tick();
    drive(1, 1, 0, 0, 0, 15);
    check_eq("reset_kills_record", 32'(record_bits), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 15);
    check_eq("reset_idle", 32'(busy), 32'd0);
    check_eq("reset_tx_count", 32'(tx_count), 32'd0);
    tick();

    // Random traffic against a fill-level buffer, with occasional jumps to edge levels.
    bu = 15;
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(199) == 0);
      rq  = ($urandom_range(99) < 60);
      tq  = ($urandom_range(99) < 50);
      ab  = ($urandom_range(15) == 0);
      rdy = ($urandom_range(1) == 1);
      if ($urandom_range(31) == 0) begin
        case ($urandom_range(7))
          0: bu = 0;
          1: bu = 1;
          2: bu = 2;
          3: bu = Cap - 1;
          4: bu = Cap;
          5: bu = Cap + 1;
          6: bu = (1 << CntW) - 1;
          default: bu = int'($urandom_range((1 << CntW) - 1));
        endcase
      end
      drive(r, rq, tq, ab, rdy, bu);
      check_eq("enables_exclusive", 32'(record_bits & output_bits), 32'd0);
      tick();
      bu = bu + int'(e_rec) - int'(e_out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
